// File: rtl/video_timing_pkg.sv
// ---------------------------------------------------------------------------
// video_timing_pkg
// Shared types and default timing for the Pocket video raster generator.
//   rgb_t        24-bit {R,G,B} pixel
//   state_t      raster controller states
//   DEF_*        default 560x409 raster at 13.745 MHz (60.01 Hz)
//   bar_colour   colour-bar lookup used by the optional test pattern
// ---------------------------------------------------------------------------
package video_timing_pkg;

    typedef logic [23:0] rgb_t;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        SETTLE    = 2'd1,
        RUN       = 2'd2
    } state_t;

    localparam int DEF_H_ACTIVE      = 400;
    localparam int DEF_H_TOTAL       = 560;
    localparam int DEF_H_DE_START    = 80;
    localparam int DEF_H_HS_POS      = 3;
    localparam int DEF_V_ACTIVE      = 360;
    localparam int DEF_V_TOTAL       = 409;
    localparam int DEF_V_DE_START    = 24;
    localparam int DEF_SETTLE_CYCLES = 1024;

    localparam int H_CNT_W  = 10;
    localparam int V_CNT_W  = 9;
    localparam int PIX_W    = 9;
    localparam int SETTLE_W = 16;

    // Bar index bits map straight onto R, G, B fully on/off.
    function automatic rgb_t bar_colour(input logic [2:0] bar);
        return {{8{bar[2]}}, {8{bar[1]}}, {8{bar[0]}}};
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// ---------------------------------------------------------------------------
// sync_2ff
// Two-flop synchronizer with asynchronous active-low reset.
// Used for the PLL lock flag and for synchronous deassertion of reset.
//   clk_i    destination clock
//   rst_n_i  asynchronous active-low reset (forces q_o to RST_VAL)
//   d_i      asynchronous input
//   q_o      synchronized output, 2-cycle latency
// ---------------------------------------------------------------------------
module sync_2ff #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/video_timing_gen.sv
// ---------------------------------------------------------------------------
// video_timing_gen
// Pixel-clock raster generator: waits for PLL lock, settles, then scans
// h/v counters, requests pixels one cycle early and registers returned RGB
// onto the scaler bus with DE/HS/VS aligned through a 3-stage pipe.
//
// Optional feature macro: VIDEO_TPG_EN (tpg_enable selects colour bars).
//
// Ports
//   clk_vid     in   video pixel clock
//   reset_n     in   async active-low reset (sync deassert internally)
//   pll_locked  in   PLL lock, asynchronous to clk_vid
//   rgb_in      in   pixel from reader, valid the cycle after pix_req
//   tpg_enable  in   test-pattern select (ignored without VIDEO_TPG_EN)
//   pix_req     out  pixel request for (pix_x, pix_y)
//   pix_x/y     out  requested column/row, held while pix_req is low
//   vid_de      out  data enable
//   vid_hs/vs   out  1-cycle sync pulses
//   vid_rgb     out  pixel, zero while vid_de is low
//   running     out  raster active
//
// state     | meaning
// WAIT_LOCK | idle, counters and outputs cleared, waiting for lock_s
// SETTLE    | lock seen, down-counting SETTLE_CYCLES before scanning
// RUN       | raster scanning
// ---------------------------------------------------------------------------
module video_timing_gen
    import video_timing_pkg::*;
#(
    parameter int H_ACTIVE      = DEF_H_ACTIVE,
    parameter int H_TOTAL       = DEF_H_TOTAL,
    parameter int H_DE_START    = DEF_H_DE_START,
    parameter int H_HS_POS      = DEF_H_HS_POS,
    parameter int V_ACTIVE      = DEF_V_ACTIVE,
    parameter int V_TOTAL       = DEF_V_TOTAL,
    parameter int V_DE_START    = DEF_V_DE_START,
    parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES
) (
    input  logic             clk_vid,
    input  logic             reset_n,
    input  logic             pll_locked,
    input  rgb_t             rgb_in,
    input  logic             tpg_enable,
    output logic             pix_req,
    output logic [PIX_W-1:0] pix_x,
    output logic [PIX_W-1:0] pix_y,
    output logic             vid_de,
    output logic             vid_hs,
    output logic             vid_vs,
    output rgb_t             vid_rgb,
    output logic             running
);

    logic rst_n_int;
    logic lock_s;

    sync_2ff #(.RST_VAL(1'b0)) u_rst_sync (
        .clk_i   (clk_vid),
        .rst_n_i (reset_n),
        .d_i     (1'b1),
        .q_o     (rst_n_int)
    );

    sync_2ff #(.RST_VAL(1'b0)) u_lock_sync (
        .clk_i   (clk_vid),
        .rst_n_i (rst_n_int),
        .d_i     (pll_locked),
        .q_o     (lock_s)
    );

    state_t               state_q, state_d;
    logic [SETTLE_W-1:0]  settle_q, settle_d;
    logic [H_CNT_W-1:0]   h_cnt_q, h_cnt_d;
    logic [V_CNT_W-1:0]   v_cnt_q, v_cnt_d;
    logic                 run_en;
    logic                 pix_vis;

    // Losing lock in RUN clears counters and pipe on the same edge the FSM
    // falls back to WAIT_LOCK.
    assign run_en  = (state_q == RUN) && lock_s;
    assign pix_vis = run_en
                   && (h_cnt_q >= H_CNT_W'(H_DE_START))
                   && (h_cnt_q <  H_CNT_W'(H_DE_START + H_ACTIVE))
                   && (v_cnt_q >= V_CNT_W'(V_DE_START))
                   && (v_cnt_q <  V_CNT_W'(V_DE_START + V_ACTIVE));

    always_ff @(posedge clk_vid or negedge rst_n_int) begin
        if (!rst_n_int) begin
            state_q  <= WAIT_LOCK;
            settle_q <= '0;
            h_cnt_q  <= '0;
            v_cnt_q  <= '0;
        end else begin
            state_q  <= state_d;
            settle_q <= settle_d;
            h_cnt_q  <= h_cnt_d;
            v_cnt_q  <= v_cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        settle_d = settle_q;
        h_cnt_d  = '0;
        v_cnt_d  = '0;
        case (state_q)
            WAIT_LOCK: begin
                if (lock_s) begin
                    state_d  = SETTLE;
                    settle_d = SETTLE_W'(SETTLE_CYCLES - 1);
                end
            end
            SETTLE: begin
                if (!lock_s) begin
                    state_d = WAIT_LOCK;
                end else if (settle_q == '0) begin
                    state_d = RUN;
                end else begin
                    settle_d = settle_q - 1'b1;
                end
            end
            RUN: begin
                if (!lock_s) begin
                    state_d = WAIT_LOCK;
                end
            end
            default: state_d = WAIT_LOCK;
        endcase

        if (run_en) begin
            if (h_cnt_q == H_CNT_W'(H_TOTAL - 1)) begin
                h_cnt_d = '0;
                v_cnt_d = (v_cnt_q == V_CNT_W'(V_TOTAL - 1)) ? '0 : v_cnt_q + 1'b1;
            end else begin
                h_cnt_d = h_cnt_q + 1'b1;
                v_cnt_d = v_cnt_q;
            end
        end
    end

    // Pipe: stage 1 = request (pix_req doubles as stage-1 DE), stage 2 =
    // reader turnaround, stage 3 = output register.
    logic             pix_req_q;
    logic [PIX_W-1:0] pix_x_q, pix_y_q;
    logic             hs1_q, vs1_q;
    logic             de2_q, hs2_q, vs2_q;
    logic             de3_q, hs3_q, vs3_q;
    rgb_t             rgb3_q;
    rgb_t             rgb_src;

`ifdef VIDEO_TPG_EN
    logic tpg2_q;
    rgb_t bar2_q;

    always_ff @(posedge clk_vid or negedge rst_n_int) begin
        if (!rst_n_int) begin
            tpg2_q <= 1'b0;
            bar2_q <= '0;
        end else if (!run_en) begin
            tpg2_q <= 1'b0;
            bar2_q <= '0;
        end else begin
            tpg2_q <= tpg_enable;
            bar2_q <= bar_colour(pix_x_q[8:6]);
        end
    end

    assign rgb_src = tpg2_q ? bar2_q : rgb_in;
`else
    // tpg_enable has no function in this build.
    logic unused_tpg;
    assign unused_tpg = tpg_enable;
    assign rgb_src    = rgb_in;
`endif

    always_ff @(posedge clk_vid or negedge rst_n_int) begin
        if (!rst_n_int) begin
            pix_req_q <= 1'b0;
            pix_x_q   <= '0;
            pix_y_q   <= '0;
            hs1_q     <= 1'b0;
            vs1_q     <= 1'b0;
            de2_q     <= 1'b0;
            hs2_q     <= 1'b0;
            vs2_q     <= 1'b0;
            de3_q     <= 1'b0;
            hs3_q     <= 1'b0;
            vs3_q     <= 1'b0;
            rgb3_q    <= '0;
        end else if (!run_en) begin
            pix_req_q <= 1'b0;
            pix_x_q   <= '0;
            pix_y_q   <= '0;
            hs1_q     <= 1'b0;
            vs1_q     <= 1'b0;
            de2_q     <= 1'b0;
            hs2_q     <= 1'b0;
            vs2_q     <= 1'b0;
            de3_q     <= 1'b0;
            hs3_q     <= 1'b0;
            vs3_q     <= 1'b0;
            rgb3_q    <= '0;
        end else begin
            pix_req_q <= pix_vis;
            if (pix_vis) begin
                pix_x_q <= PIX_W'(h_cnt_q - H_CNT_W'(H_DE_START));
                pix_y_q <= PIX_W'(v_cnt_q - V_CNT_W'(V_DE_START));
            end
            hs1_q  <= (h_cnt_q == H_CNT_W'(H_HS_POS));
            vs1_q  <= (h_cnt_q == '0) && (v_cnt_q == '0);
            de2_q  <= pix_req_q;
            hs2_q  <= hs1_q;
            vs2_q  <= vs1_q;
            de3_q  <= de2_q;
            hs3_q  <= hs2_q;
            vs3_q  <= vs2_q;
            rgb3_q <= de2_q ? rgb_src : '0;
        end
    end

    assign pix_req = pix_req_q;
    assign pix_x   = pix_x_q;
    assign pix_y   = pix_y_q;
    assign vid_de  = de3_q;
    assign vid_hs  = hs3_q;
    assign vid_vs  = vs3_q;
    assign vid_rgb = rgb3_q;
    assign running = (state_q == RUN);

endmodule

// File: tb/tb_video_timing_gen.sv
// ---------------------------------------------------------------------------
// tb_video_timing_gen
// Directed bench for video_timing_gen. Horizontal timing and settle time are
// the defaults; the frame is shortened to 6 lines (3 visible from line 2) so
// whole frames fit a short run. Raster cycle cm counts from the vid_vs cycle.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_video_timing_gen;
    import video_timing_pkg::*;

    localparam int HT    = 560;
    localparam int HA    = 400;
    localparam int HDS   = 80;
    localparam int HHS   = 3;
    localparam int VT    = 6;
    localparam int VA    = 3;
    localparam int VDS   = 2;
    localparam int SC    = 1024;
    localparam int FRAME = HT * VT;
    localparam int NV    = 16;

    logic       clk_vid = 1'b0;
    logic       reset_n;
    logic       pll_locked;
    logic       tpg_enable;
    rgb_t       rgb_in;
    logic       pix_req;
    logic [8:0] pix_x, pix_y;
    logic       vid_de, vid_hs, vid_vs;
    rgb_t       vid_rgb;
    logic       running;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk_vid = ~clk_vid;

    video_timing_gen #(
        .H_ACTIVE(HA), .H_TOTAL(HT), .H_DE_START(HDS), .H_HS_POS(HHS),
        .V_ACTIVE(VA), .V_TOTAL(VT), .V_DE_START(VDS), .SETTLE_CYCLES(SC)
    ) dut (
        .clk_vid    (clk_vid),
        .reset_n    (reset_n),
        .pll_locked (pll_locked),
        .rgb_in     (rgb_in),
        .tpg_enable (tpg_enable),
        .pix_req    (pix_req),
        .pix_x      (pix_x),
        .pix_y      (pix_y),
        .vid_de     (vid_de),
        .vid_hs     (vid_hs),
        .vid_vs     (vid_vs),
        .vid_rgb    (vid_rgb),
        .running    (running)
    );

    function automatic rgb_t src_rgb(input logic [8:0] x, input logic [8:0] y);
        return {y[6:0], x, 8'hA5};
    endfunction

    function automatic rgb_t exp_pixel(input int x, input int y);
        logic [8:0] xv;
        logic [8:0] yv;
        xv = x[8:0];
        yv = y[8:0];
`ifdef VIDEO_TPG_EN
        if (tpg_enable) return {{8{xv[8]}}, {8{xv[7]}}, {8{xv[6]}}};
`endif
        return src_rgb(xv, yv);
    endfunction

    function automatic bit vis(input int h, input int v);
        return (h >= HDS) && (h < HDS + HA) && (v >= VDS) && (v < VDS + VA);
    endfunction

    function automatic int outs_zero();
        return (pix_req === 1'b0 && pix_x === 9'd0 && pix_y === 9'd0 &&
                vid_de === 1'b0 && vid_hs === 1'b0 && vid_vs === 1'b0 &&
                vid_rgb === 24'h0 && running === 1'b0) ? 1 : 0;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reader model: sees pix_req the cycle after the counters, returns data
    // one cycle later. Filler data when idle exercises the vid_rgb zeroing.
    logic       rd_req;
    logic [8:0] rd_x, rd_y;
    initial begin
        rd_req = 1'b0;
        rd_x   = '0;
        rd_y   = '0;
        rgb_in = 24'h5A5A5A;
        forever begin
            @(posedge clk_vid);
            #1;
            rgb_in = rd_req ? src_rgb(rd_x, rd_y) : 24'h5A5A5A;
            rd_req = pix_req;
            rd_x   = pix_x;
            rd_y   = pix_y;
        end
    end

    // Spot vectors at raster cycles: expected sync/DE, DE pixel (px,py) and
    // requested coordinates (qx,qy); -1 means not checked.
    typedef struct {
        int cyc;
        int de;
        int hs;
        int vs;
        int req;
        int px;
        int py;
        int qx;
        int qy;
    } vec_t;

    vec_t vecs [NV];

    task automatic apply_vec(input int i, input string tag);
        rgb_t er;
        er = (vecs[i].de != 0) ? exp_pixel(vecs[i].px, vecs[i].py) : 24'h0;
        check($sformatf("%s v%0d de", tag, i), int'(vid_de), vecs[i].de);
        check($sformatf("%s v%0d hs", tag, i), int'(vid_hs), vecs[i].hs);
        check($sformatf("%s v%0d vs", tag, i), int'(vid_vs), vecs[i].vs);
        check($sformatf("%s v%0d req", tag, i), int'(pix_req), vecs[i].req);
        check($sformatf("%s v%0d rgb", tag, i), int'(vid_rgb), int'(er));
        if (vecs[i].qx >= 0) begin
            check($sformatf("%s v%0d pix_x", tag, i), int'(pix_x), vecs[i].qx);
            check($sformatf("%s v%0d pix_y", tag, i), int'(pix_y), vecs[i].qy);
        end
    endtask

    // Starts on the vid_vs cycle; ends on the vid_vs cycle after the last frame.
    task automatic walk(input int frames, input string tag);
        int err_sync = 0, err_rgb = 0, err_req = 0, err_xy = 0;
        int de_tot = 0, hs_tot = 0, vs_tot = 0;
        for (int c = 0; c < frames * FRAME; c++) begin
            int   cm, h, v, kq, hq, vq;
            bit   e_de, e_req;
            rgb_t e_rgb;
            cm    = c % FRAME;
            h     = cm % HT;
            v     = cm / HT;
            e_de  = vis(h, v);
            kq    = (cm + 2) % FRAME;
            hq    = kq % HT;
            vq    = kq / HT;
            e_req = vis(hq, vq);
            e_rgb = e_de ? exp_pixel(h - HDS, v - VDS) : 24'h0;
            if (vid_de !== e_de || vid_hs !== (h == HHS) || vid_vs !== (cm == 0)) err_sync++;
            if (vid_rgb !== e_rgb) err_rgb++;
            if (pix_req !== e_req) err_req++;
            if (e_req && (pix_x !== 9'(hq - HDS) || pix_y !== 9'(vq - VDS))) err_xy++;
            de_tot += int'(vid_de);
            hs_tot += int'(vid_hs);
            vs_tot += int'(vid_vs);
            for (int i = 0; i < NV; i++) begin
                if (vecs[i].cyc == cm) apply_vec(i, tag);
            end
            @(negedge clk_vid);
        end
        check({tag, " sync_pattern_errors"}, err_sync, 0);
        check({tag, " rgb_errors"}, err_rgb, 0);
        check({tag, " req_errors"}, err_req, 0);
        check({tag, " pix_xy_errors"}, err_xy, 0);
        check({tag, " de_cycles"}, de_tot, frames * HA * VA);
        check({tag, " hs_pulses"}, hs_tot, frames * VT);
        check({tag, " vs_pulses"}, vs_tot, frames);
        check({tag, " vs_at_frame_end"}, int'(vid_vs), 1);
    endtask

    task automatic lock_and_sync(input string tag);
        int n;
        pll_locked = 1'b1;
        n = 0;
        while (running !== 1'b1 && n < 3000) begin
            @(negedge clk_vid);
            n++;
        end
        check({tag, " lock_to_running"}, n, SC + 3);
        n = 0;
        while (vid_vs !== 1'b1 && n < 20) begin
            @(negedge clk_vid);
            n++;
        end
        check({tag, " running_to_vs"}, n, 3);
    endtask

    initial begin
        int err;

        vecs[0]  = '{0,    0, 0, 1, 0, -1, -1, -1, -1};
        vecs[1]  = '{3,    0, 1, 0, 0, -1, -1, -1, -1};
        vecs[2]  = '{563,  0, 1, 0, 0, -1, -1, -1, -1};
        vecs[3]  = '{1198, 0, 0, 0, 1, -1, -1,  0,  0};
        vecs[4]  = '{1199, 0, 0, 0, 1, -1, -1,  1,  0};
        vecs[5]  = '{1200, 1, 0, 0, 1,  0,  0,  2,  0};
        vecs[6]  = '{1264, 1, 0, 0, 1, 64,  0, 66,  0};
        vecs[7]  = '{1597, 1, 0, 0, 1, 397, 0, 399, 0};
        vecs[8]  = '{1598, 1, 0, 0, 0, 398, 0, 399, 0};
        vecs[9]  = '{1599, 1, 0, 0, 0, 399, 0, 399, 0};
        vecs[10] = '{1600, 0, 0, 0, 0, -1, -1, 399, 0};
        vecs[11] = '{1683, 0, 1, 0, 0, -1, -1, 399, 0};
        vecs[12] = '{1758, 0, 0, 0, 1, -1, -1,  0,  1};
        vecs[13] = '{2719, 1, 0, 0, 0, 399, 2, 399, 2};
        vecs[14] = '{2720, 0, 0, 0, 0, -1, -1, 399, 2};
        vecs[15] = '{3359, 0, 0, 0, 0, -1, -1, 399, 2};

        reset_n    = 1'b0;
        pll_locked = 1'b0;
        tpg_enable = 1'b0;
        repeat (5) @(negedge clk_vid);
        check("reset_outputs_zero", outs_zero(), 1);
        reset_n = 1'b1;

        err = 0;
        repeat (1500) begin
            @(negedge clk_vid);
            if (outs_zero() == 0) err++;
        end
        check("no_lock_idle_nonzero_cycles", err, 0);

        lock_and_sync("lock1");
        walk(2, "run");

        // Abort mid-line while DE is active (line 3, h 150).
        repeat (3 * HT + 150) @(negedge clk_vid);
        check("pre_abort_de", int'(vid_de), 1);
        check("pre_abort_rgb", int'(vid_rgb), int'(exp_pixel(150 - HDS, 3 - VDS)));
        pll_locked = 1'b0;
        repeat (2) @(negedge clk_vid);
        check("abort_running_after_2", int'(running), 1);
        @(negedge clk_vid);
        check("abort_outputs_zero_after_3", outs_zero(), 1);
        err = 0;
        repeat (100) begin
            @(negedge clk_vid);
            if (outs_zero() == 0) err++;
        end
        check("abort_hold_nonzero_cycles", err, 0);

        tpg_enable = 1'b1;
        lock_and_sync("relock");
        walk(1, "tpg");

        repeat (2 * HT + 180) @(negedge clk_vid);
        check("pre_reset_de", int'(vid_de), 1);
        #2 reset_n = 1'b0;
        #1 check("async_reset_outputs_zero", outs_zero(), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
